// File: rtl/ddr3_tester_pkg.sv
// Shared codes, FSM state encoding and the data-pattern lane function for the DDR3 tester.
package ddr3_tester_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_HASH = 2'd3;

  localparam logic [31:0] HASH_K = 32'h9E3779B1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAL,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_t;

  // v is word index plus lane number
  function automatic logic [31:0] lane_value(input logic [1:0] mode, input logic [31:0] v,
                                             input logic [31:0] seed);
    logic [31:0] r;
    case (mode)
      MODE_ADDR: r = v;
      MODE_INV:  r = ~v;
      MODE_WALK: r = 32'h1 << v[4:0];
      default:   r = (v * HASH_K) ^ seed;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Combinational pattern word: every 32-bit lane k of word index gets lane_value(index+k).
module ddr3_pattern_gen
  import ddr3_tester_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [31:0]       index,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  output logic [DATA_W-1:0] word
);

  localparam int LANES = DATA_W / 32;

  always_comb begin
    word = '0;
    for (int k = 0; k < LANES; k++) begin
      word[k*32 +: 32] = lane_value(mode, index + 32'(k), seed);
    end
  end

endmodule

// File: rtl/ddr3_mem_tester.sv
// DDR3 user-port traffic generator/checker: write a pattern over a word range, read it back
// in order, compare, and report pass/fail, error count and first failing address.
module ddr3_mem_tester
  import ddr3_tester_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int MASK_W     = 16,
  parameter int START_ADDR = 0,
  parameter int WORDS      = 4096,
  parameter int ADDR_STEP  = 8,
  parameter int MAX_OUTST  = 16,
  parameter int WDOG       = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  input  logic              loop_en,
  input  logic              init_calib_complete,
  input  logic              cmd_ready,
  output logic [2:0]        cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic              wr_data_rdy,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_en,
  output logic              wr_data_end,
  output logic [MASK_W-1:0] wr_data_mask,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic              sr_req,
  output logic              ref_req,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              cal_lost,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       pass_count,
  output state_t            dbg_state
);

  localparam int              OW        = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [31:0]     LAST_IDX  = 32'(WORDS - 1);
  localparam logic [31:0]     WDOG_LIM  = 32'(WDOG - 1);

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [31:0]       seed_q;
  logic [31:0]       wr_idx, rc_idx, rd_idx, wdog_cnt;
  logic [OW-1:0]     outst;
  logic              cmp_v, cmp_stray;
  logic [DATA_W-1:0] cmp_data, cmp_exp, wr_word, exp_word;
  logic [ADDR_W-1:0] cmp_addr;
  logic              active, wr_acc, rd_acc, rd_ok, rd_stray, wdog_hit, cal_drop;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] idx);
    logic [63:0] a;
    a = 64'(START_ADDR) + 64'(idx) * 64'(ADDR_STEP);
    return a[ADDR_W-1:0];
  endfunction

  ddr3_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
    .index(wr_idx), .mode(mode_q), .seed(seed_q), .word(wr_word)
  );

  ddr3_pattern_gen #(.DATA_W(DATA_W)) u_rd_pat (
    .index(rd_idx), .mode(mode_q), .seed(seed_q), .word(exp_word)
  );

  // Handshake: a write beat transfers on a cycle with cmd_en & cmd_ready & wr_data_rdy,
  // a read on cmd_en & cmd_ready; until then cmd/addr/wr_data stay unchanged because they
  // are derived only from state and the word counters, which move only on transfer.
  assign active   = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
  assign wr_acc   = (state == ST_WRITE) && cmd_ready && wr_data_rdy;
  assign rd_acc   = (state == ST_READ) && cmd_en && cmd_ready;
  assign rd_ok    = active && rd_data_valid && (outst != '0);
  assign rd_stray = active && rd_data_valid && (outst == '0);
  assign wdog_hit = active && (outst != '0) && !rd_data_valid && (wdog_cnt == WDOG_LIM);
  assign cal_drop = active && !init_calib_complete;

  assign wr_data_end  = wr_data_en;
  assign wr_data_mask = '0;
  assign sr_req       = 1'b0;
  assign ref_req      = 1'b0;
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd        = CMD_WRITE;
    cmd_en     = 1'b0;
    addr       = '0;
    wr_data    = '0;
    wr_data_en = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_WAIT_CAL;
      ST_WAIT_CAL: if (init_calib_complete) state_nxt = ST_WRITE;
      ST_WRITE: begin
        cmd_en     = 1'b1;
        wr_data_en = 1'b1;
        addr       = word_addr(wr_idx);
        wr_data    = wr_word;
        if (wr_acc && wr_idx == LAST_IDX) state_nxt = ST_READ;
      end
      ST_READ: begin
        cmd    = CMD_READ;
        cmd_en = (outst != OUTST_MAX);
        addr   = word_addr(rc_idx);
        if (rd_acc && rc_idx == LAST_IDX) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outst == '0 && !cmp_v && !rd_data_valid)
          state_nxt = (err_count == '0) ? ST_PASS : ST_FAIL;
      end
      ST_PASS: state_nxt = loop_en ? ST_WAIT_CAL : ST_IDLE;
      ST_FAIL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (cal_drop || wdog_hit) state_nxt = ST_FAIL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0; seed_q <= '0;
      wr_idx <= '0; rc_idx <= '0; rd_idx <= '0; wdog_cnt <= '0; outst <= '0;
      cmp_v <= 1'b0; cmp_stray <= 1'b0; cmp_data <= '0; cmp_exp <= '0; cmp_addr <= '0;
      done <= 1'b0; pass <= 1'b0; fail <= 1'b0; timeout <= 1'b0; cal_lost <= 1'b0;
      err_count <= '0; first_err_addr <= '0; pass_count <= '0;
    end else begin
      if (state == ST_WAIT_CAL) begin
        wr_idx <= '0; rc_idx <= '0; rd_idx <= '0; wdog_cnt <= '0; outst <= '0;
        cmp_v  <= 1'b0;
      end else begin
        if (wr_acc) wr_idx <= wr_idx + 32'd1;
        if (rd_acc) rc_idx <= rc_idx + 32'd1;
        if (rd_ok)  rd_idx <= rd_idx + 32'd1;
        outst     <= outst + OW'(rd_acc) - OW'(rd_ok);
        wdog_cnt  <= (active && outst != '0 && !rd_data_valid) ? wdog_cnt + 32'd1 : '0;
        cmp_v     <= rd_ok || rd_stray;
        cmp_stray <= rd_stray;
        cmp_data  <= rd_data;
        cmp_exp   <= exp_word;
        cmp_addr  <= word_addr(rd_idx);
      end
      // Compare stage: a stray beat has no address of its own, so it reports all-ones.
      if (cmp_v && (cmp_stray || cmp_data != cmp_exp)) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == '0) first_err_addr <= cmp_stray ? '1 : cmp_addr;
      end
      if (cal_drop)      cal_lost <= 1'b1;
      else if (wdog_hit) timeout  <= 1'b1;
      if (state == ST_FAIL) begin
        done <= 1'b1;
        fail <= 1'b1;
      end
      if (state == ST_PASS) begin
        pass_count <= pass_count + 16'd1;
        if (!loop_en) begin
          done <= 1'b1;
          pass <= 1'b1;
        end
      end
      if (state == ST_IDLE && start) begin
        mode_q <= mode; seed_q <= seed;
        done <= 1'b0; pass <= 1'b0; fail <= 1'b0; timeout <= 1'b0; cal_lost <= 1'b0;
        err_count <= '0; first_err_addr <= '0;
      end
    end
  end

endmodule
